// File: rtl/spi_slave_if_if.sv
// Bundle of SPI pins and the RAM-side word/read-data handshake for spi_slave_if.
// The slave modport is the serial front end; the master modport is the pin/RAM driver.
interface spi_slave_if_if #(
  parameter int WORD_W = 10,
  parameter int DATA_W = 8
);
  logic              SS_n;
  logic              MOSI;
  logic              MISO;
  logic [WORD_W-1:0] rx_data;
  logic              rx_valid;
  logic [DATA_W-1:0] tx_data;
  logic              tx_valid;

  modport slave (
    input  SS_n, MOSI, tx_data, tx_valid,
    output MISO, rx_data, rx_valid
  );

  modport master (
    output SS_n, MOSI, tx_data, tx_valid,
    input  MISO, rx_data, rx_valid
  );
endinterface

// File: rtl/spi_slave_if.sv
// SPI slave serial front end: deserialises command/data words for the RAM and
// shifts one RAM read byte back out on MISO per read-data frame.
module spi_slave_if #(
  parameter int WORD_W = 10,
  parameter int DATA_W = 8
) (
  input  logic         clk,
  input  logic         rst,
  spi_slave_if_if.slave bus
);

  typedef enum logic [2:0] {
    IDLE      = 3'd0,
    CHK_CMD   = 3'd1,
    WRITE     = 3'd2,
    READ_ADD  = 3'd3,
    READ_DATA = 3'd4
  } state_t;

  localparam logic [3:0] RX_LAST = 4'(WORD_W - 1);
  localparam logic [2:0] TX_LAST = 3'(DATA_W - 1);

  state_t              state_r;
  logic [3:0]          rx_cnt_r;
  logic [WORD_W-2:0]   rx_sr_r;
  logic                rx_done_r;
  logic [WORD_W-1:0]   rx_data_r;
  logic                rx_valid_r;
  logic                miso_r;
  logic                rd_addr_seen_r;
  logic [DATA_W-2:0]   tx_sr_r;
  logic [2:0]          tx_cnt_r;
  logic                tx_active_r;
  logic                tx_done_r;

  // Frame sequencer: command decode, word receive and one-shot byte transmit.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_r        <= IDLE;
      rx_cnt_r       <= 4'd0;
      rx_sr_r        <= '0;
      rx_done_r      <= 1'b0;
      rx_data_r      <= '0;
      rx_valid_r     <= 1'b0;
      miso_r         <= 1'b0;
      rd_addr_seen_r <= 1'b0;
      tx_sr_r        <= '0;
      tx_cnt_r       <= 3'd0;
      tx_active_r    <= 1'b0;
      tx_done_r      <= 1'b0;
    end else begin
      rx_valid_r <= 1'b0;
      // Deselect aborts any frame; rd_addr_seen survives so a read can be retried.
      if (state_r != IDLE && bus.SS_n) begin
        state_r     <= IDLE;
        rx_cnt_r    <= 4'd0;
        miso_r      <= 1'b0;
        rx_done_r   <= 1'b0;
        tx_active_r <= 1'b0;
        tx_done_r   <= 1'b0;
        tx_cnt_r    <= 3'd0;
      end else begin
        case (state_r)
          IDLE: begin
            if (!bus.SS_n) state_r <= CHK_CMD;
            else           state_r <= IDLE;
          end
          CHK_CMD: begin
            rx_cnt_r    <= 4'd0;
            rx_done_r   <= 1'b0;
            tx_active_r <= 1'b0;
            tx_done_r   <= 1'b0;
            if (!bus.MOSI)          state_r <= WRITE;
            else if (rd_addr_seen_r) state_r <= READ_DATA;
            else                     state_r <= READ_ADD;
          end
          WRITE, READ_ADD, READ_DATA: begin
            if (!rx_done_r) begin
              if (rx_cnt_r == RX_LAST) begin
                rx_data_r  <= {rx_sr_r, bus.MOSI};
                rx_valid_r <= 1'b1;
                rx_done_r  <= 1'b1;
                if (state_r == READ_ADD) rd_addr_seen_r <= 1'b1;
              end else begin
                rx_sr_r  <= {rx_sr_r[WORD_W-3:0], bus.MOSI};
                rx_cnt_r <= rx_cnt_r + 4'd1;
              end
            end else if (state_r == READ_DATA) begin
              if (tx_active_r) begin
                if (tx_cnt_r == TX_LAST) begin
                  miso_r         <= 1'b0;
                  tx_active_r    <= 1'b0;
                  tx_done_r      <= 1'b1;
                  rd_addr_seen_r <= 1'b0;
                end else begin
                  miso_r   <= tx_sr_r[DATA_W-2];
                  tx_sr_r  <= {tx_sr_r[DATA_W-3:0], 1'b0};
                  tx_cnt_r <= tx_cnt_r + 3'd1;
                end
              end else if (!tx_done_r && bus.tx_valid) begin
                // MSB leaves on the capture edge; the rest follow from the shift register.
                miso_r      <= bus.tx_data[DATA_W-1];
                tx_sr_r     <= bus.tx_data[DATA_W-2:0];
                tx_cnt_r    <= 3'd0;
                tx_active_r <= 1'b1;
              end else begin
                miso_r <= 1'b0;
              end
            end else begin
              miso_r <= 1'b0;
            end
          end
          default: state_r <= IDLE;
        endcase
      end
    end
  end

  assign bus.MISO     = miso_r;
  assign bus.rx_data  = rx_data_r;
  assign bus.rx_valid = rx_valid_r;

endmodule

// File: tb/tb_spi_slave_if.sv
// Self-checking bench for spi_slave_if: frame-level reference model with
// randomized words, tx timing and read bytes.
module tb_spi_slave_if;

  logic clk;
  logic rst;
  int   checks;
  int   failures;

  spi_slave_if_if #(.WORD_W(10), .DATA_W(8)) bus ();

  spi_slave_if #(.WORD_W(10), .DATA_W(8)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus.slave)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Observed and expected per-edge outputs for one frame
  logic       obs_v [0:63];
  logic [9:0] obs_d [0:63];
  logic       obs_m [0:63];
  logic       exp_v [0:63];
  logic [9:0] exp_d [0:63];
  logic       exp_m [0:63];
  int         n_obs;

  // Reference model state
  logic       m_seen;
  logic [9:0] m_rx;

  // Drive one frame from a negedge; sample outputs after every rising edge.
  task automatic run_frame(input logic cmd, input logic [9:0] word, input int nword,
                           input int tail, input int tx_from, input logic [7:0] tx_byte,
                           input int stop_edge);
    int last_low;
    last_low = 1 + nword + tail;
    n_obs = 0;
    for (int e = 0; e <= last_low + 2; e++) begin
      bus.SS_n = (e > last_low);
      if (e == 1)                    bus.MOSI = cmd;
      else if (e >= 2 && e < 2 + nword) bus.MOSI = word[9 - (e - 2)];
      else                           bus.MOSI = 1'($urandom_range(0, 1));
      bus.tx_valid = (tx_from >= 0 && e >= tx_from);
      bus.tx_data  = bus.tx_valid ? tx_byte : 8'($urandom);
      @(negedge clk);
      obs_v[e] = bus.rx_valid;
      obs_d[e] = bus.rx_data;
      obs_m[e] = bus.MISO;
      n_obs = e + 1;
      if (e == stop_edge) return;
    end
    bus.SS_n = 1'b1;
    bus.tx_valid = 1'b0;
  endtask

  // Frame-level expectation: which edge strobes the word, which edges carry the byte.
  task automatic model_frame(input logic cmd, input logic [9:0] word, input int nword,
                             input int tail, input int tx_from, input logic [7:0] tx_byte);
    int  last_low;
    int  cap;
    bit  full;
    bit  sending;
    last_low = 1 + nword + tail;
    full     = (nword == 10);
    cap      = (tx_from > 12) ? tx_from : 12;
    sending  = full && cmd && m_seen && tx_from >= 0 && cap <= last_low;
    for (int e = 0; e <= last_low + 2; e++) begin
      if (full && e == 11) m_rx = word;
      exp_v[e] = full && e == 11;
      exp_d[e] = m_rx;
      if (sending && e >= cap && e < cap + 8 && e <= last_low) exp_m[e] = tx_byte[7 - (e - cap)];
      else exp_m[e] = 1'b0;
    end
    if (full && cmd && !m_seen)                m_seen = 1'b1;
    else if (sending && cap + 8 <= last_low)   m_seen = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    bus.SS_n = 1'b1; bus.MOSI = 1'b0; bus.tx_valid = 1'b0; bus.tx_data = 8'h00;
    repeat (2) @(negedge clk);
    checks++; if (bus.MISO !== 1'b0) begin failures++; $display("FAIL reset_miso got=%b want=0", bus.MISO); end
    checks++; if (bus.rx_valid !== 1'b0) begin failures++; $display("FAIL reset_rx_valid got=%b want=0", bus.rx_valid); end
    checks++; if (bus.rx_data !== 10'h000) begin failures++; $display("FAIL reset_rx_data got=%h want=000", bus.rx_data); end
    checks++; if (dut.rd_addr_seen_r !== 1'b0) begin failures++; $display("FAIL reset_seen got=%b want=0", dut.rd_addr_seen_r); end
    rst = 1'b0;
    m_seen = 1'b0; m_rx = 10'h000;
    @(negedge clk);
  endtask

  task automatic test_write();
    logic [9:0] words [2];
    words[0] = 10'h012; words[1] = 10'h1A5;
    for (int f = 0; f < 2; f++) begin
      model_frame(1'b0, words[f], 10, 3, (f == 1) ? 5 : -1, 8'hFF);
      run_frame(1'b0, words[f], 10, 3, (f == 1) ? 5 : -1, 8'hFF, -1);
      for (int e = 0; e < n_obs; e++) begin
        checks++;
        if (obs_v[e] !== exp_v[e] || obs_d[e] !== exp_d[e] || obs_m[e] !== exp_m[e]) begin
          failures++;
          $display("FAIL write f%0d edge %0d got v=%b d=%h m=%b want v=%b d=%h m=%b",
                   f, e, obs_v[e], obs_d[e], obs_m[e], exp_v[e], exp_d[e], exp_m[e]);
        end
      end
      checks++;
      if (dut.rd_addr_seen_r !== m_seen) begin failures++; $display("FAIL write_seen got=%b want=%b", dut.rd_addr_seen_r, m_seen); end
    end
  endtask

  task automatic test_read_seq(input string name, input int tx_from, input int tail, input logic [7:0] byte_v);
    logic [9:0] words [2];
    words[0] = 10'h212; words[1] = 10'h300;
    for (int f = 0; f < 2; f++) begin
      model_frame(1'b1, words[f], 10, (f == 0) ? 2 : tail, (f == 0) ? -1 : tx_from, byte_v);
      run_frame(1'b1, words[f], 10, (f == 0) ? 2 : tail, (f == 0) ? -1 : tx_from, byte_v, -1);
      for (int e = 0; e < n_obs; e++) begin
        checks++;
        if (obs_v[e] !== exp_v[e] || obs_d[e] !== exp_d[e] || obs_m[e] !== exp_m[e]) begin
          failures++;
          $display("FAIL %s f%0d edge %0d got v=%b d=%h m=%b want v=%b d=%h m=%b",
                   name, f, e, obs_v[e], obs_d[e], obs_m[e], exp_v[e], exp_d[e], exp_m[e]);
        end
      end
      checks++;
      if (dut.rd_addr_seen_r !== m_seen) begin failures++; $display("FAIL %s_seen f%0d got=%b want=%b", name, f, dut.rd_addr_seen_r, m_seen); end
    end
  endtask

  task automatic test_abort();
    // Abort a write word, a read-data transfer, then retry the read in full
    logic       cmds  [4];
    int         nw    [4];
    int         tl    [4];
    int         txf   [4];
    logic [9:0] w;
    logic [7:0] b;
    cmds[0] = 1'b0; nw[0] = 5;  tl[0] = 0;  txf[0] = -1;
    cmds[1] = 1'b0; nw[1] = 10; tl[1] = 1;  txf[1] = -1;
    cmds[2] = 1'b1; nw[2] = 10; tl[2] = 4;  txf[2] = 12;
    cmds[3] = 1'b1; nw[3] = 10; tl[3] = 10; txf[3] = 12;
    b = 8'($urandom);
    for (int f = 0; f < 4; f++) begin
      if (f == 2) begin
        model_frame(1'b1, 10'h2AA, 10, 0, -1, b);
        run_frame(1'b1, 10'h2AA, 10, 0, -1, b, -1);
      end
      w = 10'($urandom);
      model_frame(cmds[f], w, nw[f], tl[f], txf[f], b);
      run_frame(cmds[f], w, nw[f], tl[f], txf[f], b, -1);
      for (int e = 0; e < n_obs; e++) begin
        checks++;
        if (obs_v[e] !== exp_v[e] || obs_d[e] !== exp_d[e] || obs_m[e] !== exp_m[e]) begin
          failures++;
          $display("FAIL abort f%0d edge %0d got v=%b d=%h m=%b want v=%b d=%h m=%b",
                   f, e, obs_v[e], obs_d[e], obs_m[e], exp_v[e], exp_d[e], exp_m[e]);
        end
      end
      checks++;
      if (dut.rd_addr_seen_r !== m_seen) begin failures++; $display("FAIL abort_seen f%0d got=%b want=%b", f, dut.rd_addr_seen_r, m_seen); end
    end
  endtask

  task automatic test_reset_mid_read();
    logic [7:0] b;
    logic [9:0] w;
    b = 8'($urandom) | 8'h08;
    w = 10'($urandom);
    if (!m_seen) begin
      model_frame(1'b1, 10'h255, 10, 0, -1, b);
      run_frame(1'b1, 10'h255, 10, 0, -1, b, -1);
    end
    model_frame(1'b1, w, 10, 15, 12, b);
    run_frame(1'b1, w, 10, 15, 12, b, 16);
    for (int e = 0; e < n_obs; e++) begin
      checks++;
      if (obs_v[e] !== exp_v[e] || obs_d[e] !== exp_d[e] || obs_m[e] !== exp_m[e]) begin
        failures++;
        $display("FAIL midrst edge %0d got v=%b d=%h m=%b want v=%b d=%h m=%b",
                 e, obs_v[e], obs_d[e], obs_m[e], exp_v[e], exp_d[e], exp_m[e]);
      end
    end
    rst = 1'b1;
    #1;
    checks++; if (bus.MISO !== 1'b0) begin failures++; $display("FAIL midrst_miso got=%b want=0", bus.MISO); end
    checks++; if (bus.rx_valid !== 1'b0) begin failures++; $display("FAIL midrst_rx_valid got=%b want=0", bus.rx_valid); end
    checks++; if (bus.rx_data !== 10'h000) begin failures++; $display("FAIL midrst_rx_data got=%h want=000", bus.rx_data); end
    checks++; if (dut.rd_addr_seen_r !== 1'b0) begin failures++; $display("FAIL midrst_seen got=%b want=0", dut.rd_addr_seen_r); end
    bus.SS_n = 1'b1; bus.tx_valid = 1'b0;
    @(negedge clk);
    rst = 1'b0;
    m_seen = 1'b0; m_rx = 10'h000;
    @(negedge clk);
  endtask

  task automatic test_random();
    logic       cmd;
    logic [9:0] w;
    logic [7:0] b;
    int         nw;
    int         tl;
    int         txf;
    for (int f = 0; f < 24; f++) begin
      cmd = 1'($urandom_range(0, 1));
      w   = 10'($urandom);
      b   = 8'($urandom);
      nw  = ($urandom_range(0, 3) == 0) ? $urandom_range(1, 9) : 10;
      tl  = (nw == 10) ? $urandom_range(0, 24) : 0;
      txf = ($urandom_range(0, 4) == 0) ? -1 : $urandom_range(0, 20);
      model_frame(cmd, w, nw, tl, txf, b);
      run_frame(cmd, w, nw, tl, txf, b, -1);
      for (int e = 0; e < n_obs; e++) begin
        checks++;
        if (obs_v[e] !== exp_v[e] || obs_d[e] !== exp_d[e] || obs_m[e] !== exp_m[e]) begin
          failures++;
          $display("FAIL random f%0d edge %0d got v=%b d=%h m=%b want v=%b d=%h m=%b",
                   f, e, obs_v[e], obs_d[e], obs_m[e], exp_v[e], exp_d[e], exp_m[e]);
        end
      end
      checks++;
      if (dut.rd_addr_seen_r !== m_seen) begin failures++; $display("FAIL random_seen f%0d got=%b want=%b", f, dut.rd_addr_seen_r, m_seen); end
    end
  endtask

  initial begin
    checks = 0;
    failures = 0;
    test_reset();
    test_write();
    test_read_seq("read_a5", 12, 12, 8'hA5);
    test_read_seq("persist_tx", 3, 25, 8'($urandom));
    test_abort();
    test_reset_mid_read();
    test_random();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
